// File: rtl/led_pkg.sv
// Shared types and elaboration-time helpers for the multiplexed LED matrix scanner.
package led_pkg;

    typedef enum logic [1:0] {
        PH_BLANK = 2'd0,
        PH_ON    = 2'd1,
        PH_OFF   = 2'd2
    } phase_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Yields 0 when a slot cannot hold BLANK plus a full brightness ramp; the matrix then stays dark.
    function automatic int unsigned scan_step(input int unsigned scan_div,
                                              input int unsigned blank,
                                              input int unsigned bright_w);
        if (scan_div < blank + (32'd1 << bright_w)) return 0;
        return (scan_div - blank) >> bright_w;
    endfunction

endpackage

// File: rtl/led_frame_buf.sv
// Double-banked line store: the client writes the back bank, the scanner reads the front bank.
module led_frame_buf
    import led_pkg::*;
#(
    parameter  int unsigned N_COLS = 4,
    parameter  int unsigned LINE_W = 8,
    localparam int unsigned CW     = idx_width(N_COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [CW-1:0]     wr_addr,
    input  logic [LINE_W-1:0] wr_data,
    input  logic              swap_en,
    input  logic [CW-1:0]     rd_addr,
    output logic [LINE_W-1:0] rd_data
);

    logic [LINE_W-1:0] mem_q [2][N_COLS];
    logic [LINE_W-1:0] mem_d [2][N_COLS];
    logic              front_sel_q;
    logic              front_sel_d;

    // A write coinciding with a swap lands in the old back bank, i.e. the new front.
    always_comb begin
        mem_d       = mem_q;
        front_sel_d = front_sel_q ^ swap_en;
        if (wr_en && (32'(wr_addr) < N_COLS)) begin
            mem_d[~front_sel_q][wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q       <= '{default: '0};
            front_sel_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            front_sel_q <= front_sel_d;
        end
    end

    assign rd_data = mem_q[front_sel_q][rd_addr];

endmodule

// File: rtl/led_matrix_scan.sv
// Column-multiplexed LED matrix driver with blanking, global PWM brightness and tear-free bank swap.
module led_matrix_scan
    import led_pkg::*;
#(
    parameter  int unsigned N_COLS   = 4,
    parameter  int unsigned LINE_W   = 8,
    parameter  int unsigned SCAN_DIV = 2048,
    parameter  int unsigned BLANK    = 16,
    parameter  int unsigned BRIGHT_W = 4,
    localparam int unsigned CW       = idx_width(N_COLS)
) (
    input  logic                clk12MHz,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_addr,
    input  logic [LINE_W-1:0]   wr_data,
    input  logic                swap_req,
    output logic                swap_ack,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic [LINE_W-1:0]   line_leds,
    output logic [N_COLS-1:0]   column_leds,
    output logic                frame_start
);

    localparam int unsigned   SW         = idx_width(SCAN_DIV);
    localparam int unsigned   STEP       = scan_step(SCAN_DIV, BLANK, BRIGHT_W);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(N_COLS - 1);

    logic [SW-1:0]       slot_cnt_q, slot_cnt_d;
    logic [CW-1:0]       col_idx_q, col_idx_d;
    logic [BRIGHT_W-1:0] bright_q, bright_d;
    logic [LINE_W-1:0]   line_q, line_d;
    phase_e              phase_q, phase_d;
    logic                swap_pend_q, swap_pend_d;
    logic                swap_ack_q, swap_ack_d;
    logic                frame_start_q, frame_start_d;
    logic [LINE_W-1:0]   line_leds_q, line_leds_d;
    logic [N_COLS-1:0]   column_leds_q, column_leds_d;

    logic                slot_wrap;
    logic                frame_end;
    logic [LINE_W-1:0]   front_word;
    logic [31:0]         on_end;

    led_frame_buf #(
        .N_COLS (N_COLS),
        .LINE_W (LINE_W)
    ) u_frame_buf (
        .clk     (clk12MHz),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .swap_en (frame_end & swap_req),
        .rd_addr (col_idx_q),
        .rd_data (front_word)
    );

    always_comb begin
        slot_wrap  = (slot_cnt_q == SLOT_LAST);
        frame_end  = slot_wrap && (col_idx_q == COL_LAST);
        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        col_idx_d  = col_idx_q;
        if (slot_wrap) begin
            col_idx_d = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;
        end
        bright_d = (slot_cnt_q == '0) ? brightness : bright_q;
        line_d   = (slot_cnt_q == '0) ? front_word : line_q;
        on_end   = 32'(BLANK) + 32'(bright_q) * STEP;
    end

    // Phase tracks the current counter value; bright_d covers BLANK==1 where ON starts right after sampling.
    always_comb begin
        phase_d = phase_q;
        unique case (phase_q)
            PH_BLANK: begin
                if (slot_cnt_q == BLANK_LAST) begin
                    phase_d = ((32'(bright_d) * STEP) != 32'd0) ? PH_ON : PH_OFF;
                end
            end
            PH_ON: begin
                if (32'(slot_cnt_q) + 32'd1 == on_end) phase_d = PH_OFF;
            end
            PH_OFF:   phase_d = PH_OFF;
            default:  phase_d = PH_BLANK;
        endcase
        if (slot_wrap) phase_d = PH_BLANK;
    end

    always_comb begin
        frame_start_d = (slot_cnt_q == '0) && (col_idx_q == '0);
        swap_pend_d   = frame_end && swap_req;
        swap_ack_d    = swap_pend_q;
        column_leds_d = '1;
        line_leds_d   = '0;
        if (phase_q == PH_ON) begin
            column_leds_d = ~(N_COLS'(1) << col_idx_q);
            line_leds_d   = line_q;
        end
    end

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q    <= '0;
            col_idx_q     <= '0;
            bright_q      <= '0;
            line_q        <= '0;
            phase_q       <= PH_BLANK;
            swap_pend_q   <= 1'b0;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            line_leds_q   <= '0;
            column_leds_q <= '1;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            col_idx_q     <= col_idx_d;
            bright_q      <= bright_d;
            line_q        <= line_d;
            phase_q       <= phase_d;
            swap_pend_q   <= swap_pend_d;
            swap_ack_q    <= swap_ack_d;
            frame_start_q <= frame_start_d;
            line_leds_q   <= line_leds_d;
            column_leds_q <= column_leds_d;
        end
    end

    assign swap_ack    = swap_ack_q;
    assign frame_start = frame_start_q;
    assign line_leds   = line_leds_q;
    assign column_leds = column_leds_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with SCAN_DIV=16, BLANK=2, BRIGHT_W=2 (STEP=3).
module tb_led_matrix_scan;

    localparam int SD    = 16;
    localparam int BL    = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       swap_req;
    logic       swap_ack;
    logic [1:0] brightness;
    logic [7:0] line_leds;
    logic [3:0] column_leds;
    logic       frame_start;

    logic       b_wr_en;
    logic [1:0] b_wr_addr;
    logic [7:0] b_wr_data;
    logic       b_swap_req;
    logic       b_swap_ack;
    logic [1:0] b_brightness;
    logic [7:0] b_line_leds;
    logic [2:0] b_column_leds;
    logic       b_frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_matrix_scan #(
        .N_COLS(4), .LINE_W(8), .SCAN_DIV(SD), .BLANK(BL), .BRIGHT_W(2)
    ) dut (
        .clk12MHz(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
        .brightness(brightness), .line_leds(line_leds),
        .column_leds(column_leds), .frame_start(frame_start)
    );

    // Three columns: exercises non-power-of-two wrap and an unrepresentable-column write.
    led_matrix_scan #(
        .N_COLS(3), .LINE_W(8), .SCAN_DIV(SD), .BLANK(BL), .BRIGHT_W(2)
    ) dut_b (
        .clk12MHz(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .swap_req(b_swap_req), .swap_ack(b_swap_ack),
        .brightness(b_brightness), .line_leds(b_line_leds),
        .column_leds(b_column_leds), .frame_start(b_frame_start)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic write_word(input logic [1:0] a, input logic [7:0] d);
        wr_addr = a; wr_data = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write_b(input logic [1:0] a, input logic [7:0] d);
        b_wr_addr = a; b_wr_data = d; b_wr_en = 1'b1;
        @(negedge clk);
        b_wr_en = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        while (frame_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL %s frame_start wait: got %b, required 1 within 200 cycles", name, frame_start);
        end
    endtask

    // Offset m after the frame_start sample shows the state of frame cycle m (column m/16, slot m%16).
    task automatic check_frame(input string name, input logic [3:0][7:0] d,
                               input logic [3:0][3:0] onc, input logic ack0);
        wait_frame(name);
        for (int m = 0; m < FRAME; m++) begin
            int         c;
            int         sc;
            logic       on;
            logic [3:0] exp_col;
            logic [7:0] exp_line;
            c        = m / SD;
            sc       = m % SD;
            on       = (sc >= BL) && (sc < BL + int'(onc[c]));
            exp_col  = on ? ~(4'b0001 << c) : 4'b1111;
            exp_line = on ? d[c] : 8'h00;
            checks += 4;
            if (column_leds !== exp_col) begin
                errors++;
                $display("FAIL %s column_leds m=%0d: got %b, required %b", name, m, column_leds, exp_col);
            end
            if (line_leds !== exp_line) begin
                errors++;
                $display("FAIL %s line_leds m=%0d: got %h, required %h", name, m, line_leds, exp_line);
            end
            if (frame_start !== (m == 0)) begin
                errors++;
                $display("FAIL %s frame_start m=%0d: got %b, required %b", name, m, frame_start, m == 0);
            end
            if (swap_ack !== ((m == 0) && ack0)) begin
                errors++;
                $display("FAIL %s swap_ack m=%0d: got %b, required %b", name, m, swap_ack, (m == 0) && ack0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0; brightness = '0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_swap_req = 1'b0; b_brightness = 2'd3;
        repeat (5) @(negedge clk);
        checks += 4;
        if (column_leds !== 4'b1111) begin errors++; $display("FAIL reset column_leds: got %b, required 1111", column_leds); end
        if (line_leds !== 8'h00) begin errors++; $display("FAIL reset line_leds: got %h, required 00", line_leds); end
        if (swap_ack !== 1'b0) begin errors++; $display("FAIL reset swap_ack: got %b, required 0", swap_ack); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL reset frame_start: got %b, required 0", frame_start); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL reset first frame_start: got %b, required 1", frame_start); end
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b0) begin errors++; $display("FAIL reset frame_start pulse width: got %b, required 0", frame_start); end
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        while (swap_ack !== 1'b1 && n < FRAME + 8) begin
            @(negedge clk);
            n++;
        end
        checks += 2;
        if (swap_ack !== 1'b1) begin errors++; $display("FAIL %s swap_ack wait: got %b, required 1", name, swap_ack); end
        if (frame_start !== 1'b1) begin errors++; $display("FAIL %s frame_start with ack: got %b, required 1", name, frame_start); end
    endtask

    task automatic test_basic_scan();
        write_word(2'd0, 8'hA5);
        write_word(2'd1, 8'h5A);
        write_word(2'd2, 8'h0F);
        write_word(2'd3, 8'hF0);
        brightness = 2'd3;
        swap_req   = 1'b1;
        wait_ack("basic");
        swap_req = 1'b0;
        check_frame("basic", {8'hF0, 8'h0F, 8'h5A, 8'hA5}, {4{4'd9}}, 1'b1);
    endtask

    task automatic test_brightness();
        fork
            check_frame("bright_mid", {8'hF0, 8'h0F, 8'h5A, 8'hA5}, {4'd3, 4'd3, 4'd9, 4'd9}, 1'b0);
            begin repeat (21) @(negedge clk); brightness = 2'd1; end
        join
        fork
            check_frame("bright_one", {8'hF0, 8'h0F, 8'h5A, 8'hA5}, {4{4'd3}}, 1'b0);
            begin repeat (50) @(negedge clk); brightness = 2'd0; end
        join
        check_frame("bright_zero", {8'hF0, 8'h0F, 8'h5A, 8'hA5}, {4{4'd0}}, 1'b0);
        brightness = 2'd3;
    endtask

    task automatic test_swap_boundary_write();
        wait_frame("swap");
        for (int m = 0; m < FRAME; m++) begin
            case (m)
                5:  swap_req = 1'b1;
                6:  begin wr_addr = 2'd0; wr_data = 8'h11; wr_en = 1'b1; end
                7:  begin wr_addr = 2'd1; wr_data = 8'h22; end
                8:  begin wr_addr = 2'd2; wr_data = 8'h33; end
                9:  begin wr_addr = 2'd3; wr_data = 8'h44; end
                10: wr_en = 1'b0;
                62: begin wr_addr = 2'd3; wr_data = 8'h99; wr_en = 1'b1; end
                63: wr_en = 1'b0;
                default: ;
            endcase
            @(negedge clk);
        end
        checks += 2;
        if (swap_ack !== 1'b1) begin errors++; $display("FAIL swap ack at frame start: got %b, required 1", swap_ack); end
        if (frame_start !== 1'b1) begin errors++; $display("FAIL swap frame_start: got %b, required 1", frame_start); end
        swap_req = 1'b0;
        check_frame("swap", {8'h99, 8'h33, 8'h22, 8'h11}, {4{4'd9}}, 1'b1);
    endtask

    task automatic test_out_of_range();
        int n = 0;
        write_b(2'd0, 8'h11);
        write_b(2'd1, 8'h22);
        write_b(2'd2, 8'h33);
        write_b(2'd3, 8'hFF);
        b_swap_req = 1'b1;
        while (b_swap_ack !== 1'b1 && n < 3 * SD + 8) begin
            @(negedge clk);
            n++;
        end
        checks += 2;
        if (b_swap_ack !== 1'b1) begin errors++; $display("FAIL oor swap_ack wait: got %b, required 1", b_swap_ack); end
        if (b_frame_start !== 1'b1) begin errors++; $display("FAIL oor frame_start: got %b, required 1", b_frame_start); end
        b_swap_req = 1'b0;
        for (int m = 0; m < 3 * SD; m++) begin
            int         c;
            int         sc;
            logic       on;
            logic [2:0] exp_col;
            logic [7:0] exp_line;
            c        = m / SD;
            sc       = m % SD;
            on       = (sc >= BL) && (sc < BL + 9);
            exp_col  = on ? ~(3'b001 << c) : 3'b111;
            exp_line = on ? 8'(8'h11 * (c + 1)) : 8'h00;
            checks += 2;
            if (b_column_leds !== exp_col) begin
                errors++;
                $display("FAIL oor column_leds m=%0d: got %b, required %b", m, b_column_leds, exp_col);
            end
            if (b_line_leds !== exp_line) begin
                errors++;
                $display("FAIL oor line_leds m=%0d: got %h, required %h", m, b_line_leds, exp_line);
            end
            @(negedge clk);
        end
        checks++;
        if (b_frame_start !== 1'b1) begin errors++; $display("FAIL oor column wrap frame_start: got %b, required 1", b_frame_start); end
    endtask

    task automatic test_reset_mid();
        wait_frame("rst_mid");
        swap_req = 1'b1;
        repeat (37) @(negedge clk);
        checks++;
        if (column_leds !== 4'b1011) begin errors++; $display("FAIL rst_mid pre column_leds: got %b, required 1011", column_leds); end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (column_leds !== 4'b1111) begin errors++; $display("FAIL rst_mid column_leds: got %b, required 1111", column_leds); end
        if (line_leds !== 8'h00) begin errors++; $display("FAIL rst_mid line_leds: got %h, required 00", line_leds); end
        if (swap_ack !== 1'b0) begin errors++; $display("FAIL rst_mid swap_ack: got %b, required 0", swap_ack); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_mid frame_start: got %b, required 0", frame_start); end
        repeat (3) @(negedge clk);
        swap_req = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL rst_mid release frame_start: got %b, required 1", frame_start); end
        check_frame("rst_mid_zero", {4{8'h00}}, {4{4'd9}}, 1'b0);
        check_frame("rst_mid_noack", {4{8'h00}}, {4{4'd9}}, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_brightness();
        test_swap_boundary_write();
        test_out_of_range();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
